ro_freq_counter: RTL and testbench
==================================

# ro_freq_counter

Measurement stage directly downstream of the ring oscillator. It drives the oscillator's Mode and Stress controls, samples its output, and counts rising edges over a fixed gate window of system clocks. It reports the count with a one-cycle valid strobe. Between measurements it can hold the ring in a DC stress condition for ageing experiments.

## Interface
Parameters:
- GATE_CYCLES, 100000: length of the counting window in clk cycles (≥1).
- SETTLE_CYCLES, 16: clk cycles the ring runs before counting starts (≥1); also flushes the synchronizer.
- CNT_WIDTH, 24: width of the edge counter and result.

Ports:
- clk  in  1  system clock; the only clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  measurement request; sampled only in IDLE.
- stress_req  in  1  level request to hold the ring in stress; honoured only from IDLE.
- ro_in  in  1  ring oscillator OUT; asynchronous to clk.
- ro_mode  out  1  to oscillator Mode; 1 = ring oscillates.
- ro_stress  out  1  to oscillator Stress; 1 = ring held static under stress.
- busy  out  1  high in SETTLE and MEASURE.
- count  out  CNT_WIDTH  last measured rising-edge count; holds until the next result.
- overflow  out  1  last result saturated; updates together with count.
- valid  out  1  one-cycle strobe; count and overflow are new this cycle.

## Operation
- ro_in passes through a 2-flop synchronizer plus a third flop for edge detection. A rising-edge pulse means the synchronized value was 0 in the previous cycle and is 1 now.
- Accurate counting requires ro_in high and low each ≥2 clk cycles. A faster ring must be prescaled before this block.
- FSM states:
  - IDLE: ro_mode=0, ro_stress=0, busy=0.
    - start=1 → SETTLE. start has priority when start and stress_req are both 1.
    - Otherwise stress_req=1 → STRESS.
  - STRESS: ro_stress=1, ro_mode=0.
    - stress_req=0 → IDLE.
    - start is ignored and not queued.
  - SETTLE: ro_mode=1, busy=1.
    - Runs SETTLE_CYCLES cycles; edge pulses are not counted.
    - On entry the edge counter clears to 0.
    - Then → MEASURE.
  - MEASURE: ro_mode=1, busy=1.
    - Runs exactly GATE_CYCLES cycles; each edge pulse in these cycles increments the counter.
    - At the edge ending the last MEASURE cycle: count ← counter (including any pulse in that last cycle), overflow ← saturation flag, valid ← 1, state → IDLE.
- Arithmetic:
  - The counter saturates at 2^CNT_WIDTH−1; it never wraps.
  - The saturation flag sets on any increment attempted at the maximum value.
  - The flag clears on SETTLE entry.
- start and stress_req changes during SETTLE/MEASURE are ignored. start must be re-asserted in IDLE to begin a new measurement.
- The gate and settle counters are sized internally via $clog2 of their parameters.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ro_mode=0, ro_stress=0, busy=0, valid=0, count=0, overflow=0.
  - Synchronizer flops and all counters clear.
  - Reset mid-measurement aborts the measurement; no valid is produced.
- If start is sampled in IDLE at cycle T:
  - SETTLE occupies cycles T+1 … T+SETTLE_CYCLES.
  - MEASURE occupies cycles T+SETTLE_CYCLES+1 … T+SETTLE_CYCLES+GATE_CYCLES.
  - valid=1 and the new count/overflow appear in cycle T+SETTLE_CYCLES+GATE_CYCLES+1; state is IDLE in that same cycle.
- start=1 in the valid cycle is accepted, so back-to-back measurements have a 1-cycle IDLE gap.
- valid is never high for two consecutive cycles.
- ro_mode/ro_stress are registered and change the cycle after the state transition decision. They are never both 1.
- Edge pulses lag ro_in by 2–3 clk cycles. A rising edge within the last 2 cycles before MEASURE ends may fall outside the window; this is accepted.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 and stress_req=1 → all outputs 0; state is IDLE after release.
- Nominal: SETTLE_CYCLES=4, GATE_CYCLES=100, ro_in period 10 clk (5 high/5 low), pulse start at T → count=10, overflow=0, valid exactly at T+105, busy high T+1…T+104.
- Saturation: CNT_WIDTH=4, ro_in period 4 clk, GATE_CYCLES=100 → count=15, overflow=1; a following run with ro_in static → count=0, overflow=0.
- Stress: stress_req=1 from IDLE → ro_stress=1, ro_mode=0 next cycle. Pulse start while stressed → no SETTLE, busy stays 0. Drop stress_req → ro_stress=0, return to IDLE.
- Priority and abort:
  - start and stress_req both rising in IDLE → SETTLE entered, ro_stress stays 0.
  - rst_n=0 mid-MEASURE → no valid; count keeps its reset value 0.
- Back-to-back: re-assert start in the valid cycle → second valid arrives exactly SETTLE_CYCLES+GATE_CYCLES+1 cycles after the first, with an independent count.

Source files
------------

// File: rtl/ro_freq_counter_if.sv
// Control/result bundle between a measurement requester and ro_freq_counter.
// The requester holds the master modport; the counter holds the slave.
interface ro_freq_counter_if #(
  parameter int CNT_WIDTH = 24
);
  logic                 start;
  logic                 stress_req;
  logic                 busy;
  logic                 valid;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output start, stress_req,
    input  busy, valid, overflow, count
  );

  modport slave (
    input  start, stress_req,
    output busy, valid, overflow, count
  );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: settles the ring, counts synchronized
// rising edges over a fixed gate window, and can park the ring in stress.
module ro_freq_counter #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  ro_freq_counter_if.slave   bus,
  input  logic               ro_in,
  output logic               ro_mode,
  output logic               ro_stress
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  typedef enum logic [1:0] {
    IDLE, STRESS, SETTLE, MEASURE
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [GW-1:0]        gate_q, gate_d;
  logic [CNT_WIDTH-1:0] edge_q, edge_d;
  logic                 sat_q, sat_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 mode_q, mode_d;
  logic                 stress_q, stress_d;
  logic                 busy_q;
  logic                 s1_q, s2_q, s3_q;
  logic                 pulse;
  logic [CNT_WIDTH-1:0] edge_nx;
  logic                 sat_nx;

  assign pulse = s2_q & ~s3_q;

  // Saturating increment; the flag latches any attempt made at the maximum.
  always_comb begin
    edge_nx = edge_q;
    sat_nx  = sat_q;
    if (pulse) begin
      if (edge_q == C_MAX) sat_nx = 1'b1;
      else edge_nx = edge_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    edge_d   = edge_q;
    sat_d    = sat_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SETTLE;
          settle_d = '0;
          edge_d   = '0;
          sat_d    = 1'b0;
        end else if (bus.stress_req) begin
          state_d = STRESS;
        end
      end
      STRESS: begin
        if (!bus.stress_req) state_d = IDLE;
      end
      SETTLE: begin
        edge_d   = '0;
        sat_d    = 1'b0;
        settle_d = settle_q + 1'b1;
        if (settle_q == S_LAST) begin
          state_d = MEASURE;
          gate_d  = '0;
        end
      end
      MEASURE: begin
        edge_d = edge_nx;
        sat_d  = sat_nx;
        gate_d = gate_q + 1'b1;
        if (gate_q == G_LAST) begin
          state_d = IDLE;
          count_d = edge_nx;
          ovf_d   = sat_nx;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    mode_d   = (state_d == SETTLE) || (state_d == MEASURE);
    stress_d = (state_d == STRESS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      stress_q <= 1'b0;
      busy_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      stress_q <= stress_d;
      busy_q   <= mode_d;
      s1_q     <= ro_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
    end
  end

  assign ro_mode      = mode_q;
  assign ro_stress    = stress_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: fixed-period table, random ring waveforms
// against an edge-counting model, plus stress/priority/abort/back-to-back.
module tb_ro_freq_counter;
  localparam int S  = 4;
  localparam int G  = 100;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SZ = 16384;

  logic clk = 0;
  logic rst_n = 0;
  logic ro_in = 0;
  logic ro_mode, ro_stress;

  ro_freq_counter_if #(.CNT_WIDTH(CW)) bus ();

  ro_freq_counter #(
    .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ro_in(ro_in), .ro_mode(ro_mode), .ro_stress(ro_stress)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n0 = 0;
  bit samp [SZ];

  // 0 = static low, 1 = square wave with half-period hp, 2 = random levels
  int mode = 0;
  int hp = 5;

  always @(posedge clk) begin
    if (cyc < SZ) samp[cyc] = ro_in;
    cyc++;
  end

  initial begin
    int pm, php, ph, cur;
    pm = 0; php = 5; ph = 0; cur = 5;
    forever begin
      @(negedge clk);
      if (mode != pm || hp != php) begin
        pm = mode; php = hp; ph = 0;
        cur = (mode == 1) ? hp : int'($urandom_range(2, 8));
      end
      if (mode == 0) ro_in = 0;
      else begin
        ph++;
        if (ph >= cur) begin
          ro_in = ~ro_in;
          ph = 0;
          cur = (mode == 1) ? hp : int'($urandom_range(2, 8));
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic set_mode(input int md, input int h);
    mode = md; hp = h;
    repeat (4) @(negedge clk);
  endtask

  // Rising edges seen through a two-flop synchronizer during the gate.
  function automatic int model_count(input int s0);
    int n = 0;
    for (int k = s0 + S; k <= s0 + S + G - 1; k++)
      if (samp[k-1] && !samp[k-2]) n++;
    return n;
  endfunction

  task automatic measure(output int vm, output int c, output int o,
                         output int bb, output int nv);
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    n0 = cyc - 1;
    vm = -1; c = -1; o = -1; bb = 0; nv = 0;
    for (int m = 0; m < S + G + 6; m++) begin
      if (m > 0) @(negedge clk);
      if (bus.busy !== (m < S + G) || ro_mode !== (m < S + G) ||
          ro_stress !== 1'b0) bb++;
      if (bus.valid === 1'b1) begin
        nv++;
        if (vm < 0) begin
          vm = m; c = int'(bus.count); o = int'(bus.overflow);
        end
      end
    end
  endtask

  task automatic wait_valid(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) at = cyc;
    end
  endtask

  typedef struct {
    int md; int h; int ec; int eo;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int vm, c, o, bb, nv, e, at1, at2, c1, nvalid;

    tbl[0] = '{1, 5, 10, 0};
    tbl[1] = '{1, 2, CMAX, 1};
    tbl[2] = '{0, 5, 0, 0};
    tbl[3] = '{1, 10, 5, 0};
    tbl[4] = '{1, 25, 2, 0};
    tbl[5] = '{1, 3, CMAX, 1};

    bus.start = 1; bus.stress_req = 1; rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.busy, bus.valid, bus.overflow, ro_mode, ro_stress}, 0);
    chk("rst_count", int'(bus.count), 0);
    bus.start = 0; bus.stress_req = 0; rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {bus.busy, ro_mode, ro_stress}, 0);

    foreach (tbl[i]) begin
      set_mode(tbl[i].md, tbl[i].h);
      measure(vm, c, o, bb, nv);
      chk($sformatf("tbl%0d_lat", i), vm, S + G);
      chk($sformatf("tbl%0d_busy", i), bb, 0);
      chk($sformatf("tbl%0d_nvalid", i), nv, 1);
      chk($sformatf("tbl%0d_count", i), c, tbl[i].ec);
      chk($sformatf("tbl%0d_ovf", i), o, tbl[i].eo);
    end

    set_mode(2, 5);
    for (int r = 0; r < 6; r++) begin
      measure(vm, c, o, bb, nv);
      e = model_count(n0);
      chk($sformatf("rnd%0d_lat", r), vm, S + G);
      chk($sformatf("rnd%0d_count", r), c, (e > CMAX) ? CMAX : e);
      chk($sformatf("rnd%0d_ovf", r), o, (e > CMAX) ? 1 : 0);
    end

    set_mode(1, 5);
    @(negedge clk); bus.stress_req = 1;
    @(negedge clk);
    chk("stress_on", {ro_stress, ro_mode}, 2'b10);
    bus.start = 1;
    @(negedge clk); bus.start = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stress_nostart", {bus.busy, ro_mode, ro_stress}, 3'b001);
    end
    bus.stress_req = 0;
    @(negedge clk);
    chk("stress_off", {bus.busy, ro_mode, ro_stress}, 0);
    repeat (3) @(negedge clk);
    chk("start_not_queued", {bus.busy, ro_mode, ro_stress}, 0);

    bus.start = 1; bus.stress_req = 1;
    @(negedge clk);
    bus.start = 0; bus.stress_req = 0;
    chk("prio_settle", {bus.busy, ro_mode, ro_stress}, 3'b110);
    wait_valid(S + G + 10, at1);
    chk("prio_done", int'(at1 >= 0), 1);

    set_mode(2, 5);
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    repeat (50) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_rst", {bus.busy, bus.valid, ro_mode}, 0);
    rst_n = 1;
    nvalid = 0;
    repeat (S + G + 20) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nvalid++;
    end
    chk("abort_novalid", nvalid, 0);
    chk("abort_count", int'(bus.count), 0);

    set_mode(1, 5);
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    wait_valid(S + G + 10, at1);
    c1 = int'(bus.count);
    bus.start = 1; mode = 1; hp = 2;
    @(negedge clk); bus.start = 0;
    chk("b2b_single_valid", int'(bus.valid), 0);
    wait_valid(S + G + 10, at2);
    chk("b2b_first", c1, 10);
    chk("b2b_gap", at2 - at1, S + G + 1);
    chk("b2b_second", int'(bus.count), CMAX);
    chk("b2b_second_ovf", int'(bus.overflow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
